succ_add_multiplier: RTL and testbench

SUCC_ADD_MULTIPLIER -- requirements
Module: succ_add_multiplier

---
 rtl/succ_add_multiplier_pkg.sv | 14 +
 rtl/succ_add_multiplier_datapath.sv | 41 ++++
 rtl/succ_add_multiplier.sv | 77 +++++++
 tb/tb_succ_add_multiplier.sv | 134 +++++++++++++
 4 files changed

// File: rtl/succ_add_multiplier_pkg.sv
// Shared types for the successive-addition multiplier: FSM state encoding and default width.
package succ_add_multiplier_pkg;

  localparam int W_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/succ_add_multiplier_datapath.sv
// Datapath for the successive-addition multiplier: A/B/P registers, adder, decrementer, zero flag.
module mult_datapath
  import succ_add_multiplier_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lda,
  input  logic             ldb,
  input  logic             clrp,
  input  logic             ldp,
  input  logic             dec,
  input  logic [W-1:0]     din,
  output logic [2*W-1:0]   product,
  output logic             eq
);

  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] p;

  assign eq      = (b == '0);
  assign product = p;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      p <= '0;
    end else begin
      if (lda) a <= din;
      // The eq guard keeps B from wrapping even if dec were asserted at zero.
      if (ldb)             b <= din;
      else if (dec && !eq) b <= b - 1'b1;
      if (clrp)     p <= '0;
      else if (ldp) p <= p + {{W{1'b0}}, a};
    end
  end

endmodule

// File: rtl/succ_add_multiplier.sv
// Successive-addition multiplier: controller FSM driving the mult_datapath strobes.
module succ_add_multiplier
  import succ_add_multiplier_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     din,
  output logic [2*W-1:0]   product,
  output logic             done,
  output logic [2:0]       state
);

  // Handshake: start is level-sampled in IDLE only; done stays high in DONE
  // until start is seen low, so a held start never triggers a second run.
  state_t cur_state;
  state_t nxt_state;
  logic   lda, ldb, clrp, ldp, dec, eq;

  assign state = cur_state;

  always_ff @(posedge clk) begin
    if (!rst_n) cur_state <= IDLE;
    else        cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    lda       = 1'b0;
    ldb       = 1'b0;
    clrp      = 1'b0;
    ldp       = 1'b0;
    dec       = 1'b0;
    done      = 1'b0;
    case (cur_state)
      IDLE:   if (start) nxt_state = LOAD_A;
      LOAD_A: begin
        lda       = 1'b1;
        nxt_state = LOAD_B;
      end
      LOAD_B: begin
        ldb       = 1'b1;
        clrp      = 1'b1;
        nxt_state = CALC;
      end
      CALC: begin
        if (eq) begin
          nxt_state = DONE;
        end else begin
          ldp = 1'b1;
          dec = 1'b1;
        end
      end
      DONE: begin
        done = 1'b1;
        if (!start) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  mult_datapath #(.W(W)) u_datapath (
    .clk     (clk),
    .rst_n   (rst_n),
    .lda     (lda),
    .ldb     (ldb),
    .clrp    (clrp),
    .ldp     (ldp),
    .dec     (dec),
    .din     (din),
    .product (product),
    .eq      (eq)
  );

endmodule

// File: tb/tb_succ_add_multiplier.sv
// Self-checking bench for succ_add_multiplier: directed cases plus random operand pairs.
module tb_succ_add_multiplier;
  import succ_add_multiplier_pkg::*;

  localparam int W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [W-1:0]     din;
  logic [2*W-1:0]   product;
  logic             done;
  logic [2:0]       state;

  int tests_run;
  int tests_failed;

  succ_add_multiplier #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .din     (din),
    .product (product),
    .done    (done),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one multiply a*b. The model: after the start edge and two load
  // edges, P shows a*i after the i-th add edge, and done appears after b+1
  // edges in CALC. abort_after >= 0 fires reset after that many adds.
  // hold_cycles keeps start high in DONE before releasing it.
  task automatic run_mult(input int a, input int b, input int hold_cycles, input int abort_after);
    logic [31:0] exp_p;
    start = 1'b1;
    din   = W'($urandom_range(0, 15));
    tick();                               // IDLE -> LOAD_A
    check("enter_load_a", state, LOAD_A);
    start = 1'($urandom_range(0, 1));
    din   = W'(a);
    tick();                               // A captured
    check("enter_load_b", state, LOAD_B);
    start = 1'($urandom_range(0, 1));
    din   = W'(b);
    tick();                               // B captured, P cleared
    din   = W'($urandom_range(0, 15));
    check("p_cleared", product, 0);
    check("calc_state", state, CALC);
    for (int i = 1; i <= b; i++) begin
      if (i - 1 == abort_after) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_state", state, IDLE);
        check("abort_product", product, 0);
        check("abort_done", done, 0);
        start = 1'b0;
        return;
      end
      start = 1'($urandom_range(0, 1));
      tick();
      exp_p = 32'(a * i);
      check("partial_sum", product, exp_p);
      check("done_low_calc", done, 0);
    end
    start = 1'($urandom_range(0, 1));
    tick();                               // CALC sees B==0 -> DONE
    exp_p = 32'(a * b);
    check("done_high", done, 1);
    check("final_product", product, exp_p);
    start = 1'b1;
    for (int h = 0; h < hold_cycles; h++) begin
      tick();
      check("hold_done", done, 1);
      check("hold_product", product, exp_p);
    end
    start = 1'b0;
    tick();
    check("back_idle", state, IDLE);
    check("idle_done_low", done, 0);
    check("idle_product_held", product, exp_p);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    start = 1'b0;
    din   = '0;
    tick();
    tick();
    check("reset_product", product, 0);
    check("reset_done", done, 0);
    check("reset_state", state, IDLE);
    rst_n = 1'b1;

    start = 1'b0;
    tick();
    check("idle_no_start", state, IDLE);

    run_mult(3, 2, 0, -1);
    run_mult(5, 0, 0, -1);
    run_mult(0, 7, 0, -1);
    run_mult(15, 15, 0, -1);
    run_mult(7, 9, 0, 3);
    run_mult(6, 5, 4, -1);
    run_mult(4, 3, 0, -1);

    for (int n = 0; n < 12; n++) begin
      run_mult(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 2)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
